// File: rtl/riscv_perf_counters.sv
// Programmable performance counters mapped onto the 0x780-0x7EF CSR window; any counter can be bound to any event input.
// Latency: an event becomes visible to counter reads 2 cycles later; CSR reads are combinational; CSR writes commit at the cycle end.
// Backpressure: none; every CSR access completes in its own cycle.
module riscv_perf_counters #(
   parameter int N_EVENTS   = 16,
   parameter int N_COUNTERS = 4,
   parameter int CNT_WIDTH  = 48,
   parameter int EVT_BITS   = $clog2(N_EVENTS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  csr_access_i,
   input  logic [11:0]           csr_addr_i,
   input  logic [31:0]           csr_wdata_i,
   input  logic [1:0]            csr_op_i,
   output logic [31:0]           csr_rdata_o,
   output logic                  csr_hit_o,
   input  logic [N_EVENTS-1:0]   events_i,
   output logic [N_COUNTERS-1:0] ovf_o,
   output logic                  ovf_irq_o
);

   localparam int HI_W   = CNT_WIDTH - 32;
   localparam int PAD_W  = 31 - EVT_BITS;
   localparam int CIDX_W = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;

   localparam logic [1:0] CSR_OP_NONE  = 2'b00;
   localparam logic [1:0] CSR_OP_WRITE = 2'b01;
   localparam logic [1:0] CSR_OP_SET   = 2'b10;
   localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

   typedef struct packed {
      logic                en;
      logic [EVT_BITS-1:0] idx;
   } evsel_t;

   logic [CNT_WIDTH-1:0]  cnt_q [N_COUNTERS];
   logic [CNT_WIDTH-1:0]  cnt_d [N_COUNTERS];
   evsel_t                evsel_q [N_COUNTERS];
   evsel_t                evsel_d [N_COUNTERS];
   logic [N_COUNTERS-1:0] inc_q, inc_d;
   logic [N_COUNTERS-1:0] ovf_q, ovf_d;
   logic [N_COUNTERS-1:0] ovfie_q, ovfie_d;
   logic [1:0]            pcmr_q, pcmr_d;
   logic                  ovf_irq_q, ovf_irq_d;
   logic [HI_W-1:0]       shadow_hi_q, shadow_hi_d;
   logic [CIDX_W-1:0]     shadow_idx_q, shadow_idx_d;
   logic                  shadow_vld_q, shadow_vld_d;

   logic [N_COUNTERS-1:0] lo_sel, hi_sel, ev_sel, ovf_set, evt_hit;
   logic                  pcmr_sel, ovf_sel, ovfie_sel, we;
   logic [31:0]           rd_view, rd_live, wval;

   always_comb begin
      lo_sel = '0;
      hi_sel = '0;
      ev_sel = '0;
      for (int k = 0; k < N_COUNTERS; k++) begin
         lo_sel[k] = (csr_addr_i == 12'(12'h780 + 2 * k));
         hi_sel[k] = (csr_addr_i == 12'(12'h781 + 2 * k));
         ev_sel[k] = (csr_addr_i == 12'(12'h7E0 + k));
      end
      pcmr_sel  = (csr_addr_i == 12'h7A1);
      ovf_sel   = (csr_addr_i == 12'h7A2);
      ovfie_sel = (csr_addr_i == 12'h7A3);
      csr_hit_o = csr_access_i & ((|lo_sel) | (|hi_sel) | (|ev_sel) | pcmr_sel | ovf_sel | ovfie_sel);
      we        = csr_hit_o & (csr_op_i != CSR_OP_NONE);
   end

   // rd_live feeds read-modify-write; rd_view is what software sees (CNTHI may come from the snapshot)
   always_comb begin
      rd_view = '0;
      rd_live = '0;
      for (int k = 0; k < N_COUNTERS; k++) begin
         if (lo_sel[k]) begin
            rd_live = cnt_q[k][31:0];
            rd_view = rd_live;
         end
         if (hi_sel[k]) begin
            rd_live = 32'(cnt_q[k][CNT_WIDTH-1:32]);
            rd_view = (shadow_vld_q && shadow_idx_q == CIDX_W'(k)) ? 32'(shadow_hi_q) : rd_live;
         end
         if (ev_sel[k]) begin
            rd_live = {evsel_q[k].en, {PAD_W{1'b0}}, evsel_q[k].idx};
            rd_view = rd_live;
         end
      end
      if (pcmr_sel) begin
         rd_live = {30'b0, pcmr_q};
         rd_view = rd_live;
      end
      if (ovf_sel) begin
         rd_live = 32'(ovf_q);
         rd_view = rd_live;
      end
      if (ovfie_sel) begin
         rd_live = 32'(ovfie_q);
         rd_view = rd_live;
      end
      csr_rdata_o = csr_hit_o ? rd_view : '0;

      case (csr_op_i)
         CSR_OP_WRITE: wval = csr_wdata_i;
         CSR_OP_SET:   wval = rd_live | csr_wdata_i;
         CSR_OP_CLEAR: wval = rd_live & ~csr_wdata_i;
         default:      wval = rd_live;
      endcase
   end

   // Stage 1: out-of-range indices never match, so such counters stay idle
   always_comb begin
      for (int k = 0; k < N_COUNTERS; k++) begin
         evt_hit[k] = 1'b0;
         for (int e = 0; e < N_EVENTS; e++) begin
            if (32'(evsel_q[k].idx) == e) evt_hit[k] = events_i[e];
         end
         inc_d[k] = pcmr_q[0] & evsel_q[k].en & evt_hit[k];
      end
   end

   // Stage 2: a CSR write to a counter drops that cycle's increment
   always_comb begin
      ovf_set = '0;
      for (int k = 0; k < N_COUNTERS; k++) begin
         cnt_d[k]   = cnt_q[k];
         evsel_d[k] = evsel_q[k];
         if (we && lo_sel[k]) begin
            cnt_d[k][31:0] = wval;
         end else if (we && hi_sel[k]) begin
            cnt_d[k][CNT_WIDTH-1:32] = wval[HI_W-1:0];
         end else if (inc_q[k]) begin
            if (&cnt_q[k]) begin
               ovf_set[k] = 1'b1;
               if (!pcmr_q[1]) cnt_d[k] = '0;
            end else begin
               cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
            end
         end
         if (we && ev_sel[k]) begin
            evsel_d[k].en  = wval[31];
            evsel_d[k].idx = wval[EVT_BITS-1:0];
         end
      end

      pcmr_d  = (we && pcmr_sel) ? wval[1:0] : pcmr_q;
      ovfie_d = (we && ovfie_sel) ? wval[N_COUNTERS-1:0] : ovfie_q;
      ovf_d   = ((we && ovf_sel) ? wval[N_COUNTERS-1:0] : ovf_q) | ovf_set;
      ovf_irq_d = |(ovf_q & ovfie_q);
   end

   always_comb begin
      shadow_hi_d  = shadow_hi_q;
      shadow_idx_d = shadow_idx_q;
      shadow_vld_d = shadow_vld_q;
      for (int k = 0; k < N_COUNTERS; k++) begin
         if (csr_access_i && lo_sel[k]) begin
            shadow_hi_d  = cnt_q[k][CNT_WIDTH-1:32];
            shadow_idx_d = CIDX_W'(k);
            shadow_vld_d = 1'b1;
         end
         if (csr_access_i && hi_sel[k] && shadow_idx_q == CIDX_W'(k)) shadow_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_COUNTERS; k++) begin
            cnt_q[k]   <= '0;
            evsel_q[k] <= '0;
         end
         inc_q        <= '0;
         ovf_q        <= '0;
         ovfie_q      <= '0;
         pcmr_q       <= 2'b01;
         ovf_irq_q    <= 1'b0;
         shadow_hi_q  <= '0;
         shadow_idx_q <= '0;
         shadow_vld_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         evsel_q      <= evsel_d;
         inc_q        <= inc_d;
         ovf_q        <= ovf_d;
         ovfie_q      <= ovfie_d;
         pcmr_q       <= pcmr_d;
         ovf_irq_q    <= ovf_irq_d;
         shadow_hi_q  <= shadow_hi_d;
         shadow_idx_q <= shadow_idx_d;
         shadow_vld_q <= shadow_vld_d;
      end
   end

   assign ovf_o     = ovf_q;
   assign ovf_irq_o = ovf_irq_q;

endmodule

// File: tb/tb_riscv_perf_counters.sv
// Directed bench for riscv_perf_counters: inputs driven at negedge, outputs sampled 1ns later.
module tb_riscv_perf_counters;
   localparam int NE = 16;
   localparam int NC = 4;
   localparam int CW = 48;

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SET   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          csr_access_i = 1'b0;
   logic [11:0]   csr_addr_i = '0;
   logic [31:0]   csr_wdata_i = '0;
   logic [1:0]    csr_op_i = OP_NONE;
   logic [31:0]   csr_rdata_o;
   logic          csr_hit_o;
   logic [NE-1:0] events_i = '0;
   logic [NC-1:0] ovf_o;
   logic          ovf_irq_o;

   int errors = 0;
   int checks = 0;
   logic [31:0] rd;
   logic        hit;

   riscv_perf_counters #(.N_EVENTS(NE), .N_COUNTERS(NC), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .csr_access_i(csr_access_i), .csr_addr_i(csr_addr_i),
      .csr_wdata_i(csr_wdata_i), .csr_op_i(csr_op_i), .csr_rdata_o(csr_rdata_o),
      .csr_hit_o(csr_hit_o), .events_i(events_i), .ovf_o(ovf_o), .ovf_irq_o(ovf_irq_o)
   );

   always #5 clk = ~clk;

   // One CSR access occupying exactly the next clock cycle.
   task automatic csr_acc(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic h);
      @(negedge clk);
      csr_access_i = 1'b1;
      csr_addr_i   = a;
      csr_op_i     = op;
      csr_wdata_i  = wd;
      #1;
      rdata = csr_rdata_o;
      h     = csr_hit_o;
      @(posedge clk);
      #1;
      csr_access_i = 1'b0;
      csr_op_i     = OP_NONE;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csr_acc(a, OP_WRITE, d, rd, hit);
   endtask

   task automatic rdreg(input logic [11:0] a);
      csr_acc(a, OP_NONE, 32'h0, rd, hit);
   endtask

   task automatic test_reset;
      logic [11:0] addrs [15];
      logic [31:0] exps [15];
      for (int i = 0; i < 8; i++) begin
         addrs[i] = 12'(12'h780 + i);
         exps[i]  = 32'h0;
      end
      for (int i = 0; i < 4; i++) begin
         addrs[8 + i] = 12'(12'h7E0 + i);
         exps[8 + i]  = 32'h0;
      end
      addrs[12] = 12'h7A1; exps[12] = 32'h1;
      addrs[13] = 12'h7A2; exps[13] = 32'h0;
      addrs[14] = 12'h7A3; exps[14] = 32'h0;
      for (int i = 0; i < 15; i++) begin
         rdreg(addrs[i]);
         checks++;
         if ({hit, rd} !== {1'b1, exps[i]}) begin
            errors++;
            $display("FAIL reset_read addr=%h got hit=%b data=%h want hit=1 data=%h", addrs[i], hit, rd, exps[i]);
         end
      end
      checks++;
      if (ovf_irq_o !== 1'b0 || ovf_o !== '0) begin
         errors++;
         $display("FAIL reset_ovf got irq=%b ovf=%b want 0/0", ovf_irq_o, ovf_o);
      end
      rdreg(12'h7A4);
      checks++;
      if ({hit, rd} !== 33'h0) begin
         errors++;
         $display("FAIL unmapped_7a4 got hit=%b data=%h want hit=0 data=0", hit, rd);
      end
      rdreg(12'h7E4);
      checks++;
      if ({hit, rd} !== 33'h0) begin
         errors++;
         $display("FAIL unmapped_7e4 got hit=%b data=%h want hit=0 data=0", hit, rd);
      end
   endtask

   task automatic test_count;
      wr(12'h7E2, 32'h8000_0005);
      rdreg(12'h7E2);
      checks++;
      if (rd !== 32'h8000_0005) begin
         errors++;
         $display("FAIL evsel2_readback got %h want 80000005", rd);
      end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         events_i = 16'h0020;
      end
      @(negedge clk);
      events_i = '0;
      rdreg(12'h784);
      checks++;
      if (rd !== 32'd7) begin
         errors++;
         $display("FAIL count_lo2 got %0d want 7", rd);
      end
      rdreg(12'h785);
      checks++;
      if (rd !== 32'd0) begin
         errors++;
         $display("FAIL count_hi2 got %h want 0", rd);
      end
      for (int k = 0; k < NC; k++) begin
         if (k == 2) continue;
         rdreg(12'(12'h780 + 2 * k));
         checks++;
         if (rd !== 32'd0) begin
            errors++;
            $display("FAIL count_other k=%0d got %h want 0", k, rd);
         end
      end
      wr(12'h7E2, 32'h0);
   endtask

   task automatic test_overflow;
      wr(12'h7E0, 32'h8000_0000);
      wr(12'h780, 32'hFFFF_FFFF);
      wr(12'h781, 32'h0000_FFFF);
      wr(12'h7A3, 32'h1);
      @(negedge clk);
      events_i = 16'h0001;
      @(negedge clk);
      events_i = '0;
      #1;
      checks++;
      if (ovf_o !== 4'b0000) begin
         errors++;
         $display("FAIL ovf_early got %b want 0000", ovf_o);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({ovf_o, ovf_irq_o} !== 5'b0001_0) begin
         errors++;
         $display("FAIL ovf_t2 got ovf=%b irq=%b want 0001/0", ovf_o, ovf_irq_o);
      end
      @(negedge clk);
      #1;
      checks++;
      if (ovf_irq_o !== 1'b1) begin
         errors++;
         $display("FAIL irq_t3 got %b want 1", ovf_irq_o);
      end
      rdreg(12'h780);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL wrap_lo got %h want 0", rd);
      end
      rdreg(12'h781);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL wrap_hi got %h want 0", rd);
      end
      rdreg(12'h7A2);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("FAIL wrap_ovf got %h want 1", rd);
      end

      csr_acc(12'h7A1, OP_SET, 32'h2, rd, hit);
      rdreg(12'h7A1);
      checks++;
      if (rd !== 32'h3) begin
         errors++;
         $display("FAIL pcmr_set got %h want 3", rd);
      end
      wr(12'h7A2, 32'h0);
      wr(12'h780, 32'hFFFF_FFFF);
      wr(12'h781, 32'h0000_FFFF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         events_i = 16'h0001;
      end
      @(negedge clk);
      events_i = '0;
      repeat (2) @(negedge clk);
      rdreg(12'h780);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL sat_lo got %h want ffffffff", rd);
      end
      rdreg(12'h781);
      checks++;
      if (rd !== 32'h0000_FFFF) begin
         errors++;
         $display("FAIL sat_hi got %h want 0000ffff", rd);
      end
      rdreg(12'h7A2);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("FAIL sat_ovf got %h want 1", rd);
      end
      csr_acc(12'h7A1, OP_CLEAR, 32'h2, rd, hit);
      wr(12'h7E0, 32'h0);
      csr_acc(12'h7A2, OP_CLEAR, 32'h1, rd, hit);
      wr(12'h7A3, 32'h0);
      rdreg(12'h7A2);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL ovf_clear got %h want 0", rd);
      end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (ovf_irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_drop got %b want 0", ovf_irq_o);
      end
   endtask

   task automatic test_shadow;
      wr(12'h7E1, 32'h8000_0003);
      events_i = 16'h0008;
      wr(12'h783, 32'h0);
      wr(12'h782, 32'hFFFF_FFFF);
      rdreg(12'h782);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL shadow_lo got %h want ffffffff", rd);
      end
      @(negedge clk);
      rdreg(12'h783);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL shadow_hi got %h want 0", rd);
      end
      rdreg(12'h783);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("FAIL live_hi got %h want 1", rd);
      end
      rdreg(12'h782);
      checks++;
      if (rd !== 32'h3) begin
         errors++;
         $display("FAIL live_lo got %h want 3", rd);
      end
      events_i = '0;
      wr(12'h7E1, 32'h0);
      repeat (3) @(negedge clk);
      rdreg(12'h782);
      wr(12'h783, 32'h5);
      rdreg(12'h783);
      checks++;
      if (rd !== 32'h5) begin
         errors++;
         $display("FAIL shadow_wr_clear got %h want 5", rd);
      end
   endtask

   task automatic test_priority;
      wr(12'h7E1, 32'h8000_0003);
      events_i = 16'h0008;
      repeat (3) @(negedge clk);
      wr(12'h782, 32'h100);
      rdreg(12'h782);
      checks++;
      if (rd !== 32'h100) begin
         errors++;
         $display("FAIL wr_vs_inc got %h want 100", rd);
      end
      rdreg(12'h782);
      checks++;
      if (rd !== 32'h101) begin
         errors++;
         $display("FAIL inc_after_wr got %h want 101", rd);
      end
      events_i = '0;
      wr(12'h7E1, 32'h0);

      wr(12'h7E3, 32'h8000_0004);
      wr(12'h786, 32'hFFFF_FFFF);
      wr(12'h787, 32'h0000_FFFF);
      wr(12'h7A2, 32'h8);
      @(negedge clk);
      events_i = 16'h0010;
      csr_acc(12'h7A2, OP_CLEAR, 32'h8, rd, hit);
      events_i = '0;
      rdreg(12'h7A2);
      checks++;
      if (rd !== 32'h8) begin
         errors++;
         $display("FAIL set_vs_clear got %h want 8", rd);
      end
      rdreg(12'h786);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("FAIL cnt3_after_wrap got %h want 1", rd);
      end
      csr_acc(12'h7A2, OP_CLEAR, 32'h8, rd, hit);
      rdreg(12'h7A2);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL plain_clear got %h want 0", rd);
      end
      wr(12'h7E3, 32'h0);
   endtask

   task automatic test_reset_midcount;
      for (int k = 0; k < NC; k++) wr(12'(12'h7E0 + k), 32'h8000_0000 | k);
      events_i = '1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < NC; k++) begin
         rdreg(12'(12'h780 + 2 * k));
         checks++;
         if (rd !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_cnt k=%0d got %h want 0", k, rd);
         end
      end
      rdreg(12'h7E0);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_evsel got %h want 0", rd);
      end
      wr(12'h7E0, 32'h8000_0000);
      for (int i = 0; i < 3; i++) begin
         rdreg(12'h780);
         checks++;
         if (rd !== ((i == 2) ? 32'h1 : 32'h0)) begin
            errors++;
            $display("FAIL rst_first_inc cyc=%0d got %h want %0d", i + 1, rd, (i == 2) ? 1 : 0);
         end
      end
      events_i = '0;
      wr(12'h7E0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset;
      test_count;
      test_overflow;
      test_shadow;
      test_priority;
      test_reset_midcount;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
